reorder_commit_unit: RTL and testbench

- In-order retirement buffer of the out-of-order core; it produces the commit stream that the writeback unit consumes.
- Dispatch allocates entries in program order. Execution units report completions out of order, tagged with the instruction ID.
- The block retires at most one completed head entry per cycle, driving registered commit outputs.
- A committed taken branch or JALR flushes all younger entries.

---
 rtl/reorder_commit_unit_pkg.sv | 14 +
 rtl/rob_entry_array.sv | 55 +++++
 rtl/reorder_commit_unit.sv | 168 ++++++++++++++++
 tb/tb_reorder_commit_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_commit_unit_pkg.sv
// reorder_commit_unit_pkg: shared PC_select encodings and sizing helper for the reorder commit unit
package reorder_commit_unit_pkg;
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/rob_entry_array.sv
// rob_entry_array: per-entry payload storage, one completion write port and one async head read port
module rob_entry_array #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int DEPTH        = 4,
  parameter int IW           = 2
) (
  input  logic                    clock,
  input  logic                    write_en,
  input  logic [IW-1:0]           write_id,
  input  logic [4:0]              write_op_reg,
  input  logic                    write_op_write,
  input  logic [DATA_WIDTH-1:0]   write_result,
  input  logic [1:0]              write_pc_select,
  input  logic [ADDRESS_BITS-1:0] write_jalr_target,
  input  logic [ADDRESS_BITS-1:0] write_branch_target,
  input  logic                    write_branch,
  input  logic [IW-1:0]           read_id,
  output logic [4:0]              read_op_reg,
  output logic                    read_op_write,
  output logic [DATA_WIDTH-1:0]   read_result,
  output logic [1:0]              read_pc_select,
  output logic [ADDRESS_BITS-1:0] read_jalr_target,
  output logic [ADDRESS_BITS-1:0] read_branch_target,
  output logic                    read_branch
);
  logic [4:0]              op_reg_mem        [DEPTH];
  logic                    op_write_mem      [DEPTH];
  logic [DATA_WIDTH-1:0]   result_mem        [DEPTH];
  logic [1:0]              pc_select_mem     [DEPTH];
  logic [ADDRESS_BITS-1:0] jalr_target_mem   [DEPTH];
  logic [ADDRESS_BITS-1:0] branch_target_mem [DEPTH];
  logic                    branch_mem        [DEPTH];

  // Payload is only meaningful while the entry's done bit is set, so it needs no reset
  always_ff @(posedge clock) begin
    if (write_en) begin
      op_reg_mem[write_id]        <= write_op_reg;
      op_write_mem[write_id]      <= write_op_write;
      result_mem[write_id]        <= write_result;
      pc_select_mem[write_id]     <= write_pc_select;
      jalr_target_mem[write_id]   <= write_jalr_target;
      branch_target_mem[write_id] <= write_branch_target;
      branch_mem[write_id]        <= write_branch;
    end
  end

  assign read_op_reg        = op_reg_mem[read_id];
  assign read_op_write      = op_write_mem[read_id];
  assign read_result        = result_mem[read_id];
  assign read_pc_select     = pc_select_mem[read_id];
  assign read_jalr_target   = jalr_target_mem[read_id];
  assign read_branch_target = branch_target_mem[read_id];
  assign read_branch        = branch_mem[read_id];
endmodule

// File: rtl/reorder_commit_unit.sv
// reorder_commit_unit: in-order retirement buffer producing the registered commit stream
module reorder_commit_unit
  import reorder_commit_unit_pkg::*;
#(
  parameter int CORE                          = 0,
  parameter int DATA_WIDTH                    = 32,
  parameter int ADDRESS_BITS                  = 20,
  parameter int NUMBER_OF_ACTIVE_INSTRUCTIONS = 4,
  localparam int IW = log2(NUMBER_OF_ACTIVE_INSTRUCTIONS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  output logic [IW-1:0]           alloc_instruction_ID,
  input  logic                    complete_valid,
  input  logic [IW-1:0]           complete_instruction_ID,
  input  logic [4:0]              complete_opReg,
  input  logic                    complete_opWrite,
  input  logic [DATA_WIDTH-1:0]   complete_result,
  input  logic [1:0]              complete_PC_select,
  input  logic [ADDRESS_BITS-1:0] complete_JALR_target,
  input  logic [ADDRESS_BITS-1:0] complete_branch_target,
  input  logic                    complete_branch,
  output logic                    valid_commit,
  output logic [IW-1:0]           commit_instruction_ID,
  output logic [4:0]              opReg,
  output logic                    opWrite,
  output logic [DATA_WIDTH-1:0]   ALU_Result,
  output logic [1:0]              PC_select_commit,
  output logic [ADDRESS_BITS-1:0] JALR_target_commit,
  output logic [ADDRESS_BITS-1:0] branch_target_commit,
  output logic                    branch_commit,
  output logic                    flush,
  output logic                    empty,
  input  logic                    report
);
  localparam int DEPTH = NUMBER_OF_ACTIVE_INSTRUCTIONS;

  logic [IW-1:0]           head;
  logic [IW-1:0]           tail;
  logic [IW:0]             count;
  logic [DEPTH-1:0]        alloc_bits;
  logic [DEPTH-1:0]        done_bits;
  logic [4:0]              head_op_reg;
  logic                    head_op_write;
  logic [DATA_WIDTH-1:0]   head_result;
  logic [1:0]              head_pc_select;
  logic [ADDRESS_BITS-1:0] head_jalr_target;
  logic [ADDRESS_BITS-1:0] head_branch_target;
  logic                    head_branch;
  logic                    commit_now;
  logic                    redirect_now;
  logic                    do_alloc;
  logic                    do_complete;

  // Everything here is a function of registered state, so alloc_ready has no input path
  assign commit_now   = alloc_bits[head] && done_bits[head];
  assign redirect_now = commit_now && (head_pc_select == PC_JALR || (head_pc_select == PC_BRANCH && head_branch));
  assign alloc_ready  = (count < (IW+1)'(DEPTH)) && !redirect_now;
  assign do_alloc     = alloc_valid && alloc_ready;
  assign do_complete  = complete_valid && alloc_bits[complete_instruction_ID] && !redirect_now;
  assign alloc_instruction_ID = tail;
  assign empty        = (count == '0);

  rob_entry_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDRESS_BITS(ADDRESS_BITS),
    .DEPTH       (DEPTH),
    .IW          (IW)
  ) entries (
    .clock              (clock),
    .write_en           (do_complete),
    .write_id           (complete_instruction_ID),
    .write_op_reg       (complete_opReg),
    .write_op_write     (complete_opWrite),
    .write_result       (complete_result),
    .write_pc_select    (complete_PC_select),
    .write_jalr_target  (complete_JALR_target),
    .write_branch_target(complete_branch_target),
    .write_branch       (complete_branch),
    .read_id            (head),
    .read_op_reg        (head_op_reg),
    .read_op_write      (head_op_write),
    .read_result        (head_result),
    .read_pc_select     (head_pc_select),
    .read_jalr_target   (head_jalr_target),
    .read_branch_target (head_branch_target),
    .read_branch        (head_branch)
  );

  // Pointer, occupancy and per-entry flag bookkeeping; a redirect wipes every younger entry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      alloc_bits <= '0;
      done_bits  <= '0;
    end else if (redirect_now) begin
      head       <= head + IW'(1);
      tail       <= head + IW'(1);
      count      <= '0;
      alloc_bits <= '0;
      done_bits  <= '0;
    end else begin
      count <= count + (IW+1)'(do_alloc) - (IW+1)'(commit_now);
      if (commit_now) begin
        head             <= head + IW'(1);
        alloc_bits[head] <= 1'b0;
        done_bits[head]  <= 1'b0;
      end
      if (do_alloc) begin
        tail             <= tail + IW'(1);
        alloc_bits[tail] <= 1'b1;
        done_bits[tail]  <= 1'b0;
      end
      if (do_complete) done_bits[complete_instruction_ID] <= 1'b1;
    end
  end

  // Registered commit beat; payload fields hold their last value between beats
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_commit          <= 1'b0;
      flush                 <= 1'b0;
      commit_instruction_ID <= '0;
      opReg                 <= '0;
      opWrite               <= 1'b0;
      ALU_Result            <= '0;
      PC_select_commit      <= '0;
      JALR_target_commit    <= '0;
      branch_target_commit  <= '0;
      branch_commit         <= 1'b0;
    end else begin
      valid_commit <= commit_now;
      flush        <= redirect_now;
      if (commit_now) begin
        commit_instruction_ID <= head;
        opReg                 <= head_op_reg;
        opWrite               <= head_op_write;
        ALU_Result            <= head_result;
        PC_select_commit      <= head_pc_select;
        JALR_target_commit    <= head_jalr_target;
        branch_target_commit  <= head_branch_target;
        branch_commit         <= head_branch;
      end
    end
  end

`ifndef SYNTHESIS
  logic [31:0] cycle;

  // Free-running cycle counter for the debug dump
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle <= '0;
    else cycle <= cycle + 32'd1;
  end

  // Debug dump of pointers and the current commit fields
  always_ff @(posedge clock) begin
    if (report)
      $display("core%0d cycle=%0d head=%0d tail=%0d count=%0d commit=%0b id=%0d rd=%0d we=%0b res=%0h pcsel=%0d flush=%0b",
               CORE, cycle, head, tail, count, valid_commit, commit_instruction_ID, opReg, opWrite,
               ALU_Result, PC_select_commit, flush);
  end
`endif
endmodule

// File: tb/tb_reorder_commit_unit.sv
// tb_reorder_commit_unit: directed checks of allocation, in-order commit, wrap, flush and reset
module tb_reorder_commit_unit;
  logic        clock;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [1:0]  alloc_instruction_ID;
  logic        complete_valid;
  logic [1:0]  complete_instruction_ID;
  logic [4:0]  complete_opReg;
  logic        complete_opWrite;
  logic [31:0] complete_result;
  logic [1:0]  complete_PC_select;
  logic [19:0] complete_JALR_target;
  logic [19:0] complete_branch_target;
  logic        complete_branch;
  logic        valid_commit;
  logic [1:0]  commit_instruction_ID;
  logic [4:0]  opReg;
  logic        opWrite;
  logic [31:0] ALU_Result;
  logic [1:0]  PC_select_commit;
  logic [19:0] JALR_target_commit;
  logic [19:0] branch_target_commit;
  logic        branch_commit;
  logic        flush;
  logic        empty;
  logic        report;
  int          checks;
  int          failures;

  reorder_commit_unit dut (
    .clock                  (clock),
    .reset                  (reset),
    .alloc_valid            (alloc_valid),
    .alloc_ready            (alloc_ready),
    .alloc_instruction_ID   (alloc_instruction_ID),
    .complete_valid         (complete_valid),
    .complete_instruction_ID(complete_instruction_ID),
    .complete_opReg         (complete_opReg),
    .complete_opWrite       (complete_opWrite),
    .complete_result        (complete_result),
    .complete_PC_select     (complete_PC_select),
    .complete_JALR_target   (complete_JALR_target),
    .complete_branch_target (complete_branch_target),
    .complete_branch        (complete_branch),
    .valid_commit           (valid_commit),
    .commit_instruction_ID  (commit_instruction_ID),
    .opReg                  (opReg),
    .opWrite                (opWrite),
    .ALU_Result             (ALU_Result),
    .PC_select_commit       (PC_select_commit),
    .JALR_target_commit     (JALR_target_commit),
    .branch_target_commit   (branch_target_commit),
    .branch_commit          (branch_commit),
    .flush                  (flush),
    .empty                  (empty),
    .report                 (report)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alloc_valid             = 1'b0;
    complete_valid          = 1'b0;
    complete_instruction_ID = '0;
    complete_opReg          = '0;
    complete_opWrite        = 1'b0;
    complete_result         = '0;
    complete_PC_select      = 2'b00;
    complete_JALR_target    = '0;
    complete_branch_target  = '0;
    complete_branch         = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic alloc_n(input int n);
    alloc_valid = 1'b1;
    repeat (n) step();
    alloc_valid = 1'b0;
  endtask

  task automatic complete(input logic [1:0] id, input logic [31:0] res, input logic [1:0] ps,
                          input logic [19:0] jt, input logic [19:0] bt, input logic br);
    complete_valid          = 1'b1;
    complete_instruction_ID = id;
    complete_opReg          = 5'(id) + 5'd1;
    complete_opWrite        = 1'b1;
    complete_result         = res;
    complete_PC_select      = ps;
    complete_JALR_target    = jt;
    complete_branch_target  = bt;
    complete_branch         = br;
    step();
    complete_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    report   = 1'b0;
    do_reset();
    chk("rst_valid", valid_commit, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_id", alloc_instruction_ID, 0);
    chk("rst_flush", flush, 0);

    // Mid-stream reset with three entries, the head already completed
    alloc_n(3);
    chk("mid_alloc_id", alloc_instruction_ID, 3);
    chk("mid_not_empty", empty, 0);
    complete(2'd0, 32'hAA, 2'b00, 20'h0, 20'h0, 1'b0);
    chk("mid_no_early_commit", valid_commit, 0);
    reset = 1'b0;
    #1;
    chk("mid_async_empty", empty, 1);
    chk("mid_async_id", alloc_instruction_ID, 0);
    chk("mid_async_valid", valid_commit, 0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("mid_post_valid0", valid_commit, 0);
    step();
    chk("mid_post_valid1", valid_commit, 0);
    chk("mid_post_empty", empty, 1);

    // In-order retirement from out-of-order completion
    do_reset();
    alloc_n(3);
    complete(2'd2, 32'd30, 2'b00, 20'h0, 20'h0, 1'b0);
    chk("ino_wait2", valid_commit, 0);
    complete(2'd1, 32'd20, 2'b00, 20'h0, 20'h0, 1'b0);
    chk("ino_wait1", valid_commit, 0);
    complete(2'd0, 32'd10, 2'b00, 20'h0, 20'h0, 1'b0);
    chk("ino_no_bypass", valid_commit, 0);
    step();
    chk("ino_c0_valid", valid_commit, 1);
    chk("ino_c0_id", commit_instruction_ID, 0);
    chk("ino_c0_res", ALU_Result, 10);
    chk("ino_c0_rd", opReg, 1);
    chk("ino_c0_we", opWrite, 1);
    step();
    chk("ino_c1_valid", valid_commit, 1);
    chk("ino_c1_id", commit_instruction_ID, 1);
    chk("ino_c1_res", ALU_Result, 20);
    step();
    chk("ino_c2_valid", valid_commit, 1);
    chk("ino_c2_id", commit_instruction_ID, 2);
    chk("ino_c2_res", ALU_Result, 30);
    chk("ino_c2_rd", opReg, 3);
    step();
    chk("ino_done_valid", valid_commit, 0);
    chk("ino_done_hold", ALU_Result, 30);
    chk("ino_done_empty", empty, 1);
    chk("ino_done_id", alloc_instruction_ID, 3);

    // Full buffer and pointer wrap
    do_reset();
    alloc_n(4);
    chk("full_ready", alloc_ready, 0);
    chk("full_id", alloc_instruction_ID, 0);
    chk("full_empty", empty, 0);
    complete(2'd0, 32'h77, 2'b00, 20'h0, 20'h0, 1'b0);
    chk("full_still_blocked", alloc_ready, 0);
    alloc_valid = 1'b1;
    step();
    chk("wrap_commit_valid", valid_commit, 1);
    chk("wrap_commit_id", commit_instruction_ID, 0);
    chk("wrap_commit_res", ALU_Result, 32'h77);
    chk("wrap_ready", alloc_ready, 1);
    chk("wrap_id", alloc_instruction_ID, 0);
    step();
    alloc_valid = 1'b0;
    chk("wrap_refull", alloc_ready, 0);
    chk("wrap_next_id", alloc_instruction_ID, 1);
    chk("wrap_no_commit", valid_commit, 0);

    // Taken branch at the head flushes all younger entries
    do_reset();
    alloc_n(4);
    complete(2'd0, 32'h5, 2'b01, 20'h0, 20'h100, 1'b1);
    complete(2'd1, 32'h6, 2'b00, 20'h0, 20'h0, 1'b0);
    chk("br_valid", valid_commit, 1);
    chk("br_id", commit_instruction_ID, 0);
    chk("br_flush", flush, 1);
    chk("br_target", branch_target_commit, 20'h100);
    chk("br_taken", branch_commit, 1);
    chk("br_pcsel", PC_select_commit, 2'b01);
    chk("br_empty", empty, 1);
    chk("br_next_id", alloc_instruction_ID, 1);
    chk("br_ready", alloc_ready, 1);
    complete(2'd2, 32'h7, 2'b00, 20'h0, 20'h0, 1'b0);
    chk("br_after_valid", valid_commit, 0);
    chk("br_after_flush", flush, 0);
    complete(2'd3, 32'h8, 2'b00, 20'h0, 20'h0, 1'b0);
    step();
    chk("br_quiet_valid", valid_commit, 0);
    chk("br_quiet_empty", empty, 1);

    // Not-taken branch, then JALR redirect
    do_reset();
    alloc_n(3);
    complete(2'd0, 32'h5, 2'b01, 20'h0, 20'h200, 1'b0);
    complete(2'd1, 32'h6, 2'b11, 20'h44, 20'h0, 1'b0);
    chk("nt_valid", valid_commit, 1);
    chk("nt_id", commit_instruction_ID, 0);
    chk("nt_flush", flush, 0);
    chk("nt_taken", branch_commit, 0);
    step();
    chk("jalr_valid", valid_commit, 1);
    chk("jalr_id", commit_instruction_ID, 1);
    chk("jalr_flush", flush, 1);
    chk("jalr_pcsel", PC_select_commit, 2'b11);
    chk("jalr_target", JALR_target_commit, 20'h44);
    chk("jalr_res", ALU_Result, 32'h6);
    chk("jalr_empty", empty, 1);
    chk("jalr_next_id", alloc_instruction_ID, 2);
    complete(2'd2, 32'h9, 2'b00, 20'h0, 20'h0, 1'b0);
    chk("jalr_discard_valid", valid_commit, 0);
    step();
    chk("jalr_discard_valid2", valid_commit, 0);
    chk("jalr_discard_empty", empty, 1);

    // Stray completion with an empty buffer
    do_reset();
    complete(2'd3, 32'hDEAD, 2'b11, 20'h1, 20'h2, 1'b1);
    chk("stray_valid0", valid_commit, 0);
    chk("stray_empty0", empty, 1);
    step();
    chk("stray_valid1", valid_commit, 0);
    step();
    chk("stray_valid2", valid_commit, 0);
    chk("stray_flush", flush, 0);
    chk("stray_empty2", empty, 1);
    chk("stray_id", alloc_instruction_ID, 0);
    chk("stray_res_hold", ALU_Result, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
